// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: forwarding encodings, opcode define and shadow-slot record for hazard_ctrl
`ifndef I_TYPE_LOAD
`define I_TYPE_LOAD 7'b0000011
`endif
package hazard_ctrl_pkg;
    localparam int RA_W = 5;
    localparam int OP_W = 7;
    // Named by where the operand lives while the consumer is in EX:
    // a producer in the EX slot has reached MEM by then, one in MEM has reached WB.
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic            is_load;
    } slot_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode-slot info, pipeline controls and forward selects between pipeline and hazard_ctrl
// slave  (hazard_ctrl): takes d_*, branch_taken, ext_stall; drives forward selects, stall_FD, bubble_E, flush_FD
// master (pipeline)   : the reverse
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int OPCODE_W   = 7
);
    logic                  d_valid;
    logic [REG_ADDR_W-1:0] d_rs1;
    logic [REG_ADDR_W-1:0] d_rs2;
    logic                  d_rs1_used;
    logic                  d_rs2_opb;
    logic                  d_rs2_store;
    logic [REG_ADDR_W-1:0] d_rd;
    logic                  d_reg_write;
    logic [OPCODE_W-1:0]   d_opcode;
    logic                  branch_taken;
    logic                  ext_stall;
    logic [1:0]            forward_select_A;
    logic [1:0]            forward_select_B;
    logic [1:0]            forward_store;
    logic                  stall_FD;
    logic                  bubble_E;
    logic                  flush_FD;
    modport slave (
        input  d_valid, d_rs1, d_rs2, d_rs1_used, d_rs2_opb, d_rs2_store,
        input  d_rd, d_reg_write, d_opcode, branch_taken, ext_stall,
        output forward_select_A, forward_select_B, forward_store,
        output stall_FD, bubble_E, flush_FD
    );
    modport master (
        output d_valid, d_rs1, d_rs2, d_rs1_used, d_rs2_opb, d_rs2_store,
        output d_rd, d_reg_write, d_opcode, branch_taken, ext_stall,
        input  forward_select_A, forward_select_B, forward_store,
        input  stall_FD, bubble_E, flush_FD
    );
endinterface

// File: rtl/hazard_ctrl_fwd_match.sv
// fwd_match: combinational forward select for one source index against the EX and MEM shadow slots
// src: source register index; ex, mem: shadow slots; sel: FWD_MEM / FWD_WB / FWD_NONE
module fwd_match
    import hazard_ctrl_pkg::*;
(
    input  logic [RA_W-1:0] src,
    input  slot_t           ex,
    input  slot_t           mem,
    output logic [1:0]      sel
);
    logic ex_hit, mem_hit, unused_ld;
    assign ex_hit    = ex.valid && ex.reg_write && ex.rd != '0 && ex.rd == src;
    assign mem_hit   = mem.valid && mem.reg_write && mem.rd != '0 && mem.rd == src;
    assign sel       = ex_hit ? FWD_MEM : mem_hit ? FWD_WB : FWD_NONE;
    assign unused_ld = ex.is_load ^ mem.is_load;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: execute-stage forwarding selects plus front-end stall/bubble/flush from a shadow EX/MEM/WB pipeline
// clock, reset (async, active high); hz: hazard_ctrl_if.slave (decode info in, controls and selects out)
// LOAD_USE_STALL_EN: adds the RUN/LU_STALL FSM that stalls one cycle on a load-use hazard
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = RA_W,
    parameter int OPCODE_W   = OP_W
)(
    input logic          clock,
    input logic          reset,
    hazard_ctrl_if.slave hz
);
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic [OPCODE_W-1:0]   opc;
    slot_t                 ex, mem, wb, ex_nxt;
    logic [1:0]            m_a, m_b, m_s, g_a, g_b, g_s;
    logic                  flush, lu_stall, load_ex, unused_wb;
    assign rs1 = hz.d_rs1;
    assign rs2 = hz.d_rs2;
    assign rd  = hz.d_rd;
    assign opc = hz.d_opcode;
    fwd_match u_a (.src(rs1), .ex(ex), .mem(mem), .sel(m_a));
    fwd_match u_b (.src(rs2), .ex(ex), .mem(mem), .sel(m_b));
    fwd_match u_s (.src(rs2), .ex(ex), .mem(mem), .sel(m_s));
    assign g_a = hz.d_rs1_used  ? m_a : FWD_NONE;
    assign g_b = hz.d_rs2_opb   ? m_b : FWD_NONE;
    assign g_s = hz.d_rs2_store ? m_s : FWD_NONE;
    // A flush with ext_stall high is deferred; upstream keeps branch_taken until the freeze ends.
    assign flush = hz.branch_taken && !hz.ext_stall;
`ifdef LOAD_USE_STALL_EN
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] LU_STALL = 1'b1;
    logic [0:0] state;
    logic       lu_hit;
    // A gated FWD_MEM select means the EX-slot instruction feeds a used source.
    assign lu_hit   = state == RUN && hz.d_valid && ex.is_load &&
                      (g_a == FWD_MEM || g_b == FWD_MEM || g_s == FWD_MEM);
    assign lu_stall = lu_hit && !hz.branch_taken;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RUN;
        else if (!hz.ext_stall) state <= lu_stall ? LU_STALL : RUN;
    end
`else
    assign lu_stall = 1'b0;
`endif
    assign load_ex     = hz.d_valid && !lu_stall && !flush;
    assign ex_nxt      = {load_ex, rd, hz.d_reg_write, opc == `I_TYPE_LOAD};
    assign hz.stall_FD = !reset && (hz.ext_stall || lu_stall);
    assign hz.bubble_E = !reset && lu_stall && !hz.ext_stall;
    assign hz.flush_FD = !reset && flush;
    // The WB slot only records retirement; the register file writes before it reads.
    assign unused_wb   = ^wb;
    // Selects follow their instruction into EX; a bubble entering EX carries no forwarding.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex                  <= '0;
            mem                 <= '0;
            wb                  <= '0;
            hz.forward_select_A <= FWD_NONE;
            hz.forward_select_B <= FWD_NONE;
            hz.forward_store    <= FWD_NONE;
        end else if (!hz.ext_stall) begin
            wb                  <= mem;
            mem                 <= ex;
            ex                  <= ex_nxt;
            hz.forward_select_A <= load_ex ? g_a : FWD_NONE;
            hz.forward_select_B <= load_ex ? g_b : FWD_NONE;
            hz.forward_store    <= load_ex ? g_s : FWD_NONE;
        end
    end
endmodule
